// File: rtl/int_unit_pipe.sv
// Two-stage valid/ready immediate/integer unit: extension, upper-immediate placement,
// register+immediate sums with carry-out, and a post-increment address accumulator.
module int_unit_pipe #(
  parameter int BITSIMM = 19,
  parameter int BITSOUT = 32,
  parameter int INTUOP  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITSIMM-1:0] immediate,
  input  logic [BITSOUT-1:0] register,
  input  logic [INTUOP-1:0]  intUOP,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSOUT-1:0] outImmediate,
  output logic               outCarry
);

  localparam int PAD = BITSOUT - BITSIMM;

  localparam logic [INTUOP-1:0] OP_ZERO     = INTUOP'(0);
  localparam logic [INTUOP-1:0] OP_ZEXT     = INTUOP'(1);
  localparam logic [INTUOP-1:0] OP_ADD_ZEXT = INTUOP'(2);
  localparam logic [INTUOP-1:0] OP_SEXT     = INTUOP'(3);
  localparam logic [INTUOP-1:0] OP_ADD_SEXT = INTUOP'(4);
  localparam logic [INTUOP-1:0] OP_UPPER    = INTUOP'(5);
  localparam logic [INTUOP-1:0] OP_ACC_LOAD = INTUOP'(6);
  localparam logic [INTUOP-1:0] OP_ACC_STEP = INTUOP'(7);

  if (BITSIMM < 1 || BITSIMM >= BITSOUT) begin : g_bad_imm_width
    $error("int_unit_pipe: BITSIMM must satisfy 1 <= BITSIMM < BITSOUT");
  end
  if (INTUOP < 3) begin : g_bad_op_width
    $error("int_unit_pipe: INTUOP must be at least 3");
  end

  // Stage 1 holds the operands with the immediate already extended.
  logic               s1_valid_q;
  logic [INTUOP-1:0]  s1_op_q;
  logic [BITSOUT-1:0] s1_reg_q;
  logic [BITSOUT-1:0] s1_ext_q;
  logic [BITSOUT-1:0] s1_ext_d;

  logic               out_valid_q;
  logic [BITSOUT-1:0] out_res_q;
  logic [BITSOUT-1:0] out_res_d;
  logic               out_carry_q;
  logic               out_carry_d;

  logic [BITSOUT-1:0] acc_q;
  logic [BITSOUT-1:0] acc_d;

  logic [BITSOUT-1:0] z_ext;
  logic [BITSOUT-1:0] s_ext;
  logic [BITSOUT-1:0] u_ext;
  logic [BITSOUT:0]   add_wide;
  logic               s2_free;
  logic               accept;
  logic               move;
  logic               drain;

  assign z_ext = {{PAD{1'b0}}, immediate};
  assign s_ext = {{PAD{immediate[BITSIMM-1]}}, immediate};
  assign u_ext = {immediate, {PAD{1'b0}}};

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;
  assign move     = s1_valid_q && s2_free;
  assign drain    = out_valid_q && out_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    s1_ext_d = '0;
    case (intUOP)
      OP_ZEXT, OP_ADD_ZEXT:                  s1_ext_d = z_ext;
      OP_SEXT, OP_ADD_SEXT,
      OP_ACC_LOAD, OP_ACC_STEP:              s1_ext_d = s_ext;
      OP_UPPER:                              s1_ext_d = u_ext;
      default:                               s1_ext_d = '0;
    endcase
  end

  assign add_wide = {1'b0, s1_reg_q} + {1'b0, s1_ext_q};

  always_comb begin
    out_res_d   = '0;
    out_carry_d = 1'b0;
    acc_d       = acc_q;
    case (s1_op_q)
      OP_ZERO: out_res_d = '0;
      OP_ZEXT, OP_SEXT, OP_UPPER: out_res_d = s1_ext_q;
      OP_ADD_ZEXT, OP_ADD_SEXT: begin
        out_res_d   = add_wide[BITSOUT-1:0];
        out_carry_d = add_wide[BITSOUT];
      end
      OP_ACC_LOAD: begin
        out_res_d   = add_wide[BITSOUT-1:0];
        out_carry_d = add_wide[BITSOUT];
        acc_d       = add_wide[BITSOUT-1:0];
      end
      // Post-increment: report the current value, then advance by the extended step.
      OP_ACC_STEP: begin
        out_res_d = acc_q;
        acc_d     = acc_q + s1_ext_q;
      end
      default: out_res_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_reg_q    <= '0;
      s1_ext_q    <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_carry_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_op_q    <= intUOP;
        s1_reg_q   <= register;
        s1_ext_q   <= s1_ext_d;
      end else if (move) begin
        s1_valid_q <= 1'b0;
      end

      // The accumulator advances only when its op leaves stage 1, keeping program order.
      if (move) begin
        out_valid_q <= 1'b1;
        out_res_q   <= out_res_d;
        out_carry_q <= out_carry_d;
        acc_q       <= acc_d;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign outImmediate = out_res_q;
  assign outCarry     = out_carry_q;

endmodule
